// File: rtl/pe_shift.sv
// Single-request shift engine: decodes one 64-bit op word, computes a 32-bit
// shift/rotate with a log barrel, and hands the registered result downstream.

module pe_shift_stage #(
   parameter int SH = 1
) (
   input  logic [31:0] din,
   input  logic        en,
   input  logic        rot,
   input  logic        fill,
   output logic [31:0] dout
);

   logic [SH-1:0] top;

   always_comb begin
      top  = rot ? din[SH-1:0] : {SH{fill}};
      dout = en ? {top, din[31:SH]} : din;
   end

endmodule

module pe_shift (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_drive,
   input  logic [63:0] i_data,
   output logic        o_free,
   output logic        o_drive,
   output logic [63:0] o_data,
   input  logic        i_free
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   state_t      state;
   logic [31:0] a;
   logic [4:0]  amt;
   logic [1:0]  op;
   logic        is_sll;
   logic        rot;
   logic        fill;
   logic [31:0] src;
   logic [31:0] res;
   logic [31:0] stg [0:5];
   logic        unused_bits;

   function automatic logic [31:0] bitrev(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   assign a           = i_data[31:0];
   assign amt         = i_data[36:32];
   assign op          = i_data[38:37];
   assign unused_bits = ^i_data[63:39];

   // Left shift reuses the right-shift barrel by reversing bits on both sides.
   always_comb begin
      is_sll = (op == OP_SLL);
      rot    = (op == OP_ROR);
      fill   = (op == OP_SRA) & a[31];
      src    = is_sll ? bitrev(a) : a;
      res    = is_sll ? bitrev(stg[5]) : stg[5];
   end

   assign stg[0] = src;

   for (genvar k = 0; k < 5; k++) begin : g_stage
      pe_shift_stage #(.SH(1 << k)) u_stage (
         .din  (stg[k]),
         .en   (amt[k]),
         .rot  (rot),
         .fill (fill),
         .dout (stg[k+1])
      );
   end

   // Requests seen while BUSY are dropped; o_data only changes on capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         o_free  <= 1'b1;
         o_drive <= 1'b0;
         o_data  <= 64'h0;
      end else begin
         case (state)
            IDLE: begin
               o_drive <= 1'b0;
               if (i_drive) begin
                  o_data  <= {32'h0, res};
                  o_drive <= 1'b1;
                  o_free  <= 1'b0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               o_drive <= 1'b0;
               if (i_free) begin
                  o_free <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               o_free  <= 1'b1;
               o_drive <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_shift.sv
// Directed bench for pe_shift: shift/rotate vectors, handshake hold, async reset.

module tb_pe_shift;

   logic        clk;
   logic        rst;
   logic        i_drive;
   logic [63:0] i_data;
   logic        o_free;
   logic        o_drive;
   logic [63:0] o_data;
   logic        i_free;

   int pass_cnt = 0;
   int total    = 0;

   pe_shift dut (
      .clk     (clk),
      .rst     (rst),
      .i_drive (i_drive),
      .i_data  (i_data),
      .o_free  (o_free),
      .o_drive (o_drive),
      .o_data  (o_data),
      .i_free  (i_free)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   // Issue one request with i_free high; expect pulse then return to IDLE.
   task automatic run_op(input string tag, input logic [63:0] d, input logic [31:0] r);
      @(negedge clk);
      i_drive = 1'b1;
      i_data  = d;
      i_free  = 1'b1;
      @(negedge clk);
      i_drive = 1'b0;
      check({tag, " drive"}, {63'h0, o_drive}, 64'h1);
      check({tag, " data"}, o_data, {32'h0, r});
      check({tag, " busy"}, {63'h0, o_free}, 64'h0);
      @(negedge clk);
      check({tag, " pulse_end"}, {63'h0, o_drive}, 64'h0);
      check({tag, " free"}, {63'h0, o_free}, 64'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      logic [63:0] d;
      rst = 1'b0; i_drive = 1'b0; i_data = 64'h0; i_free = 1'b1;
      #23;
      check("rst free",  {63'h0, o_free},  64'h1);
      check("rst drive", {63'h0, o_drive}, 64'h0);
      check("rst data",  o_data,           64'h0);
      @(negedge clk);
      rst = 1'b1;

      run_op("sll1",   64'h00000001_00000001, 32'h00000002);
      check("sll1 full", o_data, 64'h00000000_00000002);
      run_op("srl4",   64'h00000024_80000000, 32'h08000000);
      run_op("sra4",   64'h00000044_80000000, 32'hF8000000);
      run_op("ror8",   64'h00000068_12345678, 32'h78123456);
      run_op("sll0",   64'h00000000_DEADBEEF, 32'hDEADBEEF);
      run_op("srl0",   64'h00000020_DEADBEEF, 32'hDEADBEEF);
      run_op("sra0",   64'h00000040_DEADBEEF, 32'hDEADBEEF);
      run_op("ror0",   64'h00000060_DEADBEEF, 32'hDEADBEEF);
      run_op("sll31",  64'h0000001F_00000001, 32'h80000000);
      run_op("srl31",  64'h0000003F_80000000, 32'h00000001);
      run_op("sra31",  64'h0000005F_80000000, 32'hFFFFFFFF);
      run_op("ror31",  64'h0000007F_00000001, 32'h00000002);
      run_op("sra_pos",64'h00000044_70000000, 32'h07000000);

      // Upper ignored bits randomized; low 39 bits fixed to ROR by 8.
      for (int i = 0; i < 4; i++) begin
         d = {$urandom, 32'h12345678};
         d[38:32] = 7'h68;
         run_op("rand_hi", d, 32'h78123456);
      end

      // Downstream stalls: second request must be ignored.
      @(negedge clk);
      i_drive = 1'b1; i_data = 64'h00000004_00000001; i_free = 1'b0;
      @(negedge clk);
      check("stall drive", {63'h0, o_drive}, 64'h1);
      check("stall data",  o_data, 64'h10);
      i_data = 64'h00000001_00000003;
      @(negedge clk);
      check("stall nodrv", {63'h0, o_drive}, 64'h0);
      check("stall busy",  {63'h0, o_free},  64'h0);
      check("stall hold",  o_data, 64'h10);
      @(negedge clk);
      check("stall busy2", {63'h0, o_free},  64'h0);
      check("stall nodrv2",{63'h0, o_drive}, 64'h0);
      i_drive = 1'b0; i_free = 1'b1;
      @(negedge clk);
      check("release free", {63'h0, o_free}, 64'h1);
      check("idle hold",    o_data, 64'h10);
      run_op("after_stall", 64'h00000001_00000003, 32'h00000006);

      // i_drive held high with i_free high: one capture every other cycle.
      @(negedge clk);
      i_drive = 1'b1; i_data = 64'h00000002_00000001; i_free = 1'b1;
      @(negedge clk);
      check("held c1", {63'h0, o_drive}, 64'h1);
      check("held d1", o_data, 64'h4);
      @(negedge clk);
      check("held c2", {63'h0, o_drive}, 64'h0);
      check("held f2", {63'h0, o_free},  64'h1);
      @(negedge clk);
      check("held c3", {63'h0, o_drive}, 64'h1);
      @(negedge clk);
      check("held c4", {63'h0, o_drive}, 64'h0);
      i_drive = 1'b0;

      // Async reset during the o_drive cycle.
      @(negedge clk);
      i_drive = 1'b1; i_data = 64'h00000003_00000001; i_free = 1'b0;
      @(negedge clk);
      i_drive = 1'b0;
      check("pre_rst drive", {63'h0, o_drive}, 64'h1);
      #2 rst = 1'b0;
      #1;
      check("arst free",  {63'h0, o_free},  64'h1);
      check("arst drive", {63'h0, o_drive}, 64'h0);
      check("arst data",  o_data,           64'h0);
      @(negedge clk);
      check("arst hold",  {63'h0, o_free},  64'h1);
      rst = 1'b1;
      run_op("post_rst", 64'h00000068_AABBCCDD, 32'hDDAABBCC);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
